// File: rtl/fifo_pkg.sv
// Shared FIFO sizing helpers and defaults, used by sync_fifo and the crossbar port logic.
package fifo_pkg;

   localparam int DEFAULT_DWIDTH = 32;
   localparam int DEFAULT_DEPTH  = 16;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [$clog2(DEFAULT_DEPTH):0] level_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo: one write port, one registered read port (block-RAM style).
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int DWIDTH = DEFAULT_DWIDTH,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic                        clk_i,
   input  logic                        we_i,
   input  logic [ptr_width(DEPTH)-1:0] waddr_i,
   input  logic [DWIDTH-1:0]           wdata_i,
   input  logic [ptr_width(DEPTH)-1:0] raddr_i,
   output logic [DWIDTH-1:0]           rdata_o
);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rdata_q;

   // Read-before-write on an address collision; the FIFO bypasses that case itself.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock first-word-fall-through FIFO with level and almost-full/empty flags.
// Define SYNC_FIFO_ERR_EN to add the sticky overflow/underflow outputs.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DWIDTH        = DEFAULT_DWIDTH,
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          push,
   input  logic [DWIDTH-1:0]             push_data,
   output logic                          full,
   output logic                          almost_full,
   input  logic                          pop,
   output logic [DWIDTH-1:0]             pop_data,
   output logic                          not_empty,
   output logic                          almost_empty,
   output logic [level_width(DEPTH)-1:0] level
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                          overflow,
   output logic                          underflow
`endif
);

   localparam int PW = ptr_width(DEPTH);
   localparam int LW = level_width(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL   = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AE_LVL   = LW'(AEMPTY_THRESH);

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              byp_sel_q, byp_sel_d;
   logic [DWIDTH-1:0] byp_data_q, byp_data_d;
   logic [PW-1:0]     rd_addr;
   logic [DWIDTH-1:0] mem_rdata;
   logic              wr_en, rd_en;

   // The head is read from RAM unless it was written on the same edge it became head;
   // then it is captured straight from push_data.
   always_comb begin
      wr_en      = push & (level_q != FULL_LVL);
      rd_en      = pop & (level_q != '0);
      rd_addr    = rd_ptr_q + PW'(rd_en);
      wr_ptr_d   = wr_ptr_q + PW'(wr_en);
      rd_ptr_d   = rd_addr;
      level_d    = level_q + LW'(wr_en) - LW'(rd_en);
      byp_sel_d  = wr_en & (wr_ptr_q == rd_addr);
      byp_data_d = byp_sel_d ? push_data : byp_data_q;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         byp_sel_q  <= 1'b1;
         byp_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         byp_sel_q  <= byp_sel_d;
         byp_data_q <= byp_data_d;
      end
   end

   sync_fifo_mem #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i   (aclk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (push_data),
      .raddr_i (rd_addr),
      .rdata_o (mem_rdata)
   );

   assign pop_data     = byp_sel_q ? byp_data_q : mem_rdata;
   assign level        = level_q;
   assign full         = (level_q == FULL_LVL);
   assign not_empty    = (level_q != '0);
   assign almost_full  = (level_q >= AF_LVL);
   assign almost_empty = (level_q <= AE_LVL);

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push && full)       overflow_q  <= 1'b1;
         if (pop && !not_empty)  underflow_q <= 1'b1;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule
